receiver_spi_mc: RTL
====================

Name: receiver_spi_mc

Overview:
Parametrised multi-channel successor to the single-channel SPI receiver. It edge-detects NCH independent new_sig strobes and captures each channel's word into a per-channel holding register. A round-robin arbiter drains the holding registers into a shared tagged FIFO, which presents words to the consumer through a valid/ready handshake. It sits between the SPI front-end deserialisers and the network packet assembler.

Parameters:
WIDTH, 32, data word width per channel
NCH, 4, number of input channels (>=2)
DEPTH, 8, output FIFO entries (power of 2, >=2)
CW, max(1,$clog2(NCH)), channel tag width (derived, not overridden)

Ports:
clk  in  1  system clock, all state on posedge
rst_n  in  1  asynchronous active-low reset
new_sig  in  NCH  per-channel word-available level; a rising edge means a new word
in_sig  in  NCH*WIDTH  channel c word at [c*WIDTH +: WIDTH]
out_ready  in  1  consumer accepts head word
drop_clr  in  1  clears all drop_flag bits
processed_sig  out  WIDTH  FIFO head data
out_chan  out  CW  FIFO head channel tag
sig_alert  out  1  head valid (FIFO non-empty)
fifo_level  out  $clog2(DEPTH)+1  current FIFO occupancy
drop_flag  out  NCH  sticky per-channel overrun flag

Behaviour:
- Reset (async assert, sync deassert handled upstream) clears all state. Outputs after reset: processed_sig=0, out_chan=0, sig_alert=0, fifo_level=0, drop_flag=0. new_sig_q=0, pending=0, rr_ptr=0.
- Edge detect: new_sig_q registered each cycle; edge[c] = new_sig[c] & ~new_sig_q[c]. A level held high gives exactly one capture. new_sig high at the first cycle out of reset counts as an edge.
- Capture, on an edge[c] cycle:
  - If pending[c]=0, or channel c is granted this same cycle: hold[c] <= in_sig slice, pending[c] <= 1.
  - Otherwise the word is dropped, hold[c] is unchanged, and drop_flag[c] <= 1.
- Arbiter runs every cycle with push_ok = (fifo_level < DEPTH), using registered level; a same-cycle pop does not free space.
  - If push_ok and any pending bit is set: grant the first pending channel searching from rr_ptr upward, with modulo NCH wrap.
  - On a grant: push {c, hold[c]}, clear pending[c] unless re-set by a same-cycle edge, and set rr_ptr <= (c+1) mod NCH.
  - No grant: rr_ptr holds.
- FIFO: wr_ptr and rd_ptr wrap modulo DEPTH. pop = sig_alert & out_ready.
  - fifo_level +1 on push only, -1 on pop only, unchanged on both.
  - processed_sig and out_chan show the head entry combinationally from storage. Both are 0 when empty.
  - out_ready while empty is ignored.
- sig_alert = (fifo_level != 0).
- Latency, uncontended and empty: edge sampled at posedge k sets pending; grant at k+1; sig_alert high after k+1. That is 2 cycles from new_sig rise to sig_alert.
- FIFO full: pending words wait in hold registers with no loss. Loss happens only on a second edge while a word is still pending.
- drop_clr: clears drop_flag the next cycle. A drop in the same cycle as drop_clr wins (the flag stays set).
- Reset mid-operation: all pending and FIFO contents are discarded and outputs return to their reset values immediately.

Test Plan:
- Single word: ch0 in=50000, new_sig[0] 0->1 -> sig_alert rises 2 cycles later, processed_sig=50000, out_chan=0. Pulse out_ready one cycle -> sig_alert=0, fifo_level=0.
- Simultaneous capture: ch0=32, ch1=7, ch3=99 edges in the same cycle, rr_ptr=0, out_ready=0 -> FIFO order (0,32), (1,7), (3,99); fifo_level=3.
- Round-robin fairness: after a grant to ch3, edges on ch0 and ch2 together -> ch0 is granted first (wrap). Next contention starting at rr_ptr=1 -> ch2 before ch0.
- Full/backpressure: out_ready=0, 9 sequential single-channel words with DEPTH=8 -> fifo_level=8 and the 9th stays pending with drop_flag=0. A 10th edge on the same channel -> drop_flag set. Drain all -> 9 words in order.
- Level hold: new_sig[2] held high for 20 cycles with in_sig changing -> exactly one capture (the first value).
- Mid-operation reset: rst_n low with fifo_level=5 and pending=4'b1010 -> outputs 0 immediately. After release, one new edge yields only the new word.

Source files
------------

// File: rtl/receiver_spi_mc.sv
// receiver_spi_mc: multi-channel SPI word capture with round-robin drain into a tagged FIFO
// Each channel holds one word; a second edge while still pending is counted as an overrun.
module receiver_spi_mc #(
    parameter int WIDTH = 32,
    parameter int NCH   = 4,
    parameter int DEPTH = 8,
    localparam int CW   = (NCH > 1) ? $clog2(NCH) : 1,
    localparam int AW   = $clog2(DEPTH),
    localparam int LW   = AW + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NCH-1:0]       new_sig,
    input  logic [NCH*WIDTH-1:0] in_sig,
    input  logic                 out_ready,
    input  logic                 drop_clr,
    output logic [WIDTH-1:0]     processed_sig,
    output logic [CW-1:0]        out_chan,
    output logic                 sig_alert,
    output logic [LW-1:0]        fifo_level,
    output logic [NCH-1:0]       drop_flag
);
    logic [NCH-1:0]   r_new_q, r_pending, r_drop;
    logic [WIDTH-1:0] r_hold [NCH];
    logic [CW-1:0]    r_rr;
    logic [WIDTH-1:0] r_mem_d [DEPTH];
    logic [CW-1:0]    r_mem_c [DEPTH];
    logic [AW-1:0]    r_wr, r_rd;
    logic [LW-1:0]    r_level;
    logic [NCH-1:0]   w_edge, w_gnt_m, w_cap;
    logic             w_gnt_v, w_push, w_pop;
    logic [CW-1:0]    w_gnt_c;

    function automatic logic [CW-1:0] rr_idx(input logic [CW-1:0] p, input int i);
        int s;
        s = int'(p) + i;
        return CW'(s >= NCH ? s - NCH : s);
    endfunction

    always_comb begin
        w_gnt_v = 1'b0;
        w_gnt_c = '0;
        for (int i = 0; i < NCH; i++)
            if (!w_gnt_v && r_pending[rr_idx(r_rr, i)]) begin
                w_gnt_v = 1'b1;
                w_gnt_c = rr_idx(r_rr, i);
            end
    end

    // space check uses the registered level, so a same-cycle pop never frees a slot
    assign w_push  = w_gnt_v && (r_level < LW'(DEPTH));
    assign w_gnt_m = w_push ? (NCH'(1) << w_gnt_c) : '0;
    assign w_edge  = new_sig & ~r_new_q;
    assign w_cap   = w_edge & (~r_pending | w_gnt_m);
    assign w_pop   = (r_level != '0) && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_new_q   <= '0;
            r_pending <= '0;
            r_drop    <= '0;
            r_rr      <= '0;
            r_wr      <= '0;
            r_rd      <= '0;
            r_level   <= '0;
            for (int c = 0; c < NCH; c++) r_hold[c] <= '0;
        end else begin
            r_new_q   <= new_sig;
            r_pending <= (r_pending & ~w_gnt_m) | w_cap;
            r_drop    <= (r_drop & ~{NCH{drop_clr}}) | (w_edge & ~w_cap);
            for (int c = 0; c < NCH; c++)
                if (w_cap[c]) r_hold[c] <= in_sig[c*WIDTH +: WIDTH];
            if (w_push) begin
                r_rr <= rr_idx(w_gnt_c, 1);
                r_wr <= r_wr + AW'(1);
            end
            if (w_pop) r_rd <= r_rd + AW'(1);
            if (w_push != w_pop) r_level <= w_push ? r_level + LW'(1) : r_level - LW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_d[r_wr] <= r_hold[w_gnt_c];
            r_mem_c[r_wr] <= w_gnt_c;
        end
    end

    assign sig_alert     = r_level != '0;
    assign processed_sig = sig_alert ? r_mem_d[r_rd] : '0;
    assign out_chan      = sig_alert ? r_mem_c[r_rd] : '0;
    assign fifo_level    = r_level;
    assign drop_flag     = r_drop;
endmodule
